// File: rtl/capture_dump_ctrl.sv
// Capture/dump sequencer for the I/Q sample buffer: arm by UART command, fill the SPRAM
// array on a trigger edge, then drain it to the UART transmitter as bytes, low byte first.
module capture_dump_ctrl #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  CMD_ARM   = 8'h61,
    parameter logic [7:0]  CMD_ABORT = 8'h73
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_data,
    input  logic              trig,
    input  logic              smp_stb,
    input  logic [15:0]       smp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [15:0]       ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [2:0]        state_o,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        RD      = 3'd3,
        SEND_LO = 3'd4,
        SEND_HI = 3'd5,
        WAIT_TX = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, state_nx;
    logic              trig_d;
    logic [ADDR_W-1:0] addr_nx;
    logic [15:0]       wdata_nx;
    logic              wren_nx;
    logic [7:0]        txd_nx;
    logic              txs_nx;
    logic              done_nx;
    logic              sent_hi, sent_hi_nx;
    logic              tx_first, tx_first_nx;
    logic [7:0]        hi_byte, hi_byte_nx;
    logic              abort;
    logic              last_wr;

    assign abort   = cmd_valid && (cmd_data == CMD_ABORT);
    // The write currently on the bus is the final one; a strobe arriving now must not wrap.
    assign last_wr = ram_wren && (ram_addr == LAST);
    assign state_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            trig_d    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            done      <= 1'b0;
            sent_hi   <= 1'b0;
            tx_first  <= 1'b0;
            hi_byte   <= '0;
        end else begin
            state     <= state_nx;
            trig_d    <= trig;
            ram_addr  <= addr_nx;
            ram_wdata <= wdata_nx;
            ram_wren  <= wren_nx;
            tx_data   <= txd_nx;
            tx_start  <= txs_nx;
            done      <= done_nx;
            sent_hi   <= sent_hi_nx;
            tx_first  <= tx_first_nx;
            hi_byte   <= hi_byte_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        addr_nx     = ram_addr;
        wdata_nx    = ram_wdata;
        wren_nx     = 1'b0;
        txd_nx      = tx_data;
        txs_nx      = 1'b0;
        done_nx     = 1'b0;
        sent_hi_nx  = sent_hi;
        tx_first_nx = 1'b0;
        hi_byte_nx  = hi_byte;
        if (abort) begin
            state_nx = IDLE;
            addr_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && (cmd_data == CMD_ARM))
                        state_nx = ARMED;
                end
                ARMED: begin
                    if (trig && !trig_d) begin
                        state_nx = CAPTURE;
                        addr_nx  = '0;
                    end
                end
                CAPTURE: begin
                    // Address advances after each write cycle, so back-to-back strobes
                    // land on consecutive words.
                    if (ram_wren)
                        addr_nx = ram_addr + 1'b1;
                    if (last_wr) begin
                        state_nx = RD;
                    end else if (smp_stb) begin
                        wren_nx  = 1'b1;
                        wdata_nx = smp_data;
                    end
                end
                RD: state_nx = SEND_LO;
                SEND_LO: begin
                    if (!tx_busy) begin
                        txd_nx      = ram_rdata[7:0];
                        hi_byte_nx  = ram_rdata[15:8];
                        txs_nx      = 1'b1;
                        sent_hi_nx  = 1'b0;
                        tx_first_nx = 1'b1;
                        state_nx    = WAIT_TX;
                    end
                end
                SEND_HI: begin
                    if (!tx_busy) begin
                        txd_nx      = hi_byte;
                        txs_nx      = 1'b1;
                        sent_hi_nx  = 1'b1;
                        tx_first_nx = 1'b1;
                        state_nx    = WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    // Busy from acia_tx lags tx_start by one cycle; skip that first look.
                    if (!tx_first && !tx_busy) begin
                        if (!sent_hi) begin
                            state_nx = SEND_HI;
                        end else if (ram_addr == LAST) begin
                            done_nx  = 1'b1;
                            addr_nx  = '0;
                            state_nx = IDLE;
                        end else begin
                            addr_nx  = ram_addr + 1'b1;
                            state_nx = RD;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Randomized bench for capture_dump_ctrl (ADDR_W=3): SPRAM and acia_tx models plus a
// queue-based expectation of stored words and transmitted bytes.
module tb_capture_dump_ctrl;
    localparam int          AW    = 3;
    localparam int          DEPTH = 8;
    localparam logic [7:0]  ARM   = 8'h61;
    localparam logic [7:0]  ABT   = 8'h73;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd_data = 8'h00;
    logic          trig = 1'b0;
    logic          smp_stb = 1'b0;
    logic [15:0]   smp_data = 16'h0;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic          ram_wren;
    logic [15:0]   ram_rdata = 16'h0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [2:0]    state_o;
    logic          done;

    capture_dump_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .trig(trig),
        .smp_stb(smp_stb), .smp_data(smp_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wren(ram_wren), .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .state_o(state_o), .done(done)
    );

    always #5 clk = ~clk;

    // SPRAM: synchronous write, registered read
    logic [15:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // acia_tx: busy rises the cycle after tx_start, lasts busy_len cycles
    int busy_len = 5;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wa_q[$], wd_q[$], wc_q[$], tb_q[$], tc_q[$], exp_q[$];
    int done_cnt = 0;
    int bad_start = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (ram_wren) begin
                wa_q.push_back(int'(ram_addr));
                wd_q.push_back(int'(ram_wdata));
                wc_q.push_back(cyc);
            end
            if (tx_start) begin
                tb_q.push_back(int'(tx_data));
                tc_q.push_back(cyc);
                if (tx_busy) bad_start = bad_start + 1;
            end
            if (done) done_cnt = done_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        tb_q.delete(); tc_q.delete(); exp_q.delete();
        done_cnt  = 0;
        bad_start = 0;
    endtask

    task automatic arm_and_trig();
        trig = 1'b0;
        tick();
        send_cmd(ARM);
        chk("armed", int'(state_o), 1);
        trig = 1'b1;
        tick();
        chk("capture_on_edge", int'(state_o), 2);
        trig = 1'b0;
    endtask

    task automatic feed(input int n, input int gap_max, input bit seq);
        logic [15:0] d;
        for (int k = 0; k < n; k++) begin
            d = seq ? 16'(16'h0100 + k) : 16'($urandom);
            exp_q.push_back(int'(d));
            smp_stb  = 1'b1;
            smp_data = d;
            tick();
            smp_stb  = 1'b0;
            smp_data = 16'($urandom);
            repeat ($urandom_range(gap_max, 0)) tick();
        end
    endtask

    task automatic wait_done(input bit inject_arm);
        bit injected = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            if (inject_arm && !injected && state_o == 3'd6) begin
                send_cmd(ARM);
                injected = 1'b1;
            end else begin
                tick();
            end
        end
        chk("done_seen", int'(done_cnt != 0), 1);
        repeat (3) tick();
    endtask

    task automatic check_capture();
        chk("wr_count", wa_q.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < wa_q.size(); k++) begin
            chk($sformatf("wr_addr%0d", k), wa_q[k], k);
            chk($sformatf("wr_data%0d", k), wd_q[k], exp_q[k]);
        end
        chk("tx_count", tb_q.size(), 2 * DEPTH);
        for (int k = 0; k < DEPTH && 2 * k + 1 < tb_q.size(); k++) begin
            chk($sformatf("tx_lo%0d", k), tb_q[2*k],   exp_q[k] & 8'hff);
            chk($sformatf("tx_hi%0d", k), tb_q[2*k+1], (exp_q[k] >> 8) & 8'hff);
        end
        chk("done_once", done_cnt, 1);
        chk("end_idle", int'(state_o), 0);
        chk("end_addr", int'(ram_addr), 0);
        chk("start_while_busy", bad_start, 0);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_state", int'(state_o), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_txs", int'(tx_start), 0);
        chk("rst_txd", int'(tx_data), 0);
        chk("rst_done", int'(done), 0);
        tick();
        rst = 1'b1;
        tick();

        // stray byte, strobe and trigger in IDLE are ignored
        clear_mon();
        send_cmd(8'h78);
        chk("x_ignored", int'(state_o), 0);
        smp_stb = 1'b1; trig = 1'b1;
        tick();
        smp_stb = 1'b0; trig = 1'b0;
        tick();
        chk("idle_no_write", wa_q.size(), 0);
        chk("idle_stays", int'(state_o), 0);

        // incrementing samples, slow UART, an 'a' injected during dump
        clear_mon();
        busy_len = 5;
        arm_and_trig();
        feed(DEPTH, 3, 1'b1);
        wait_done(1'b1);
        check_capture();
        begin
            int min_sp = 1000;
            for (int i = 1; i < tc_q.size(); i++)
                if (tc_q[i] - tc_q[i-1] < min_sp) min_sp = tc_q[i] - tc_q[i-1];
            chk("tx_spacing_ge7", int'(min_sp >= 7), 1);
        end

        // back-to-back strobes, random data, random busy length
        clear_mon();
        busy_len = $urandom_range(6, 1);
        arm_and_trig();
        feed(DEPTH, 0, 1'b0);
        wait_done(1'b0);
        check_capture();
        if (wc_q.size() == DEPTH)
            chk("b2b_consecutive", wc_q[DEPTH-1] - wc_q[0], DEPTH - 1);
        else
            chk("b2b_wr_count", wc_q.size(), DEPTH);

        // trigger already high at arm time needs a fresh rising edge
        trig = 1'b1;
        repeat (2) tick();
        send_cmd(ARM);
        chk("held_armed", int'(state_o), 1);
        repeat (3) tick();
        chk("held_still_armed", int'(state_o), 1);
        trig = 1'b0;
        tick();
        chk("fall_armed", int'(state_o), 1);
        trig = 1'b1;
        tick();
        chk("rearm_capture", int'(state_o), 2);
        trig = 1'b0;
        send_cmd(ABT);
        chk("abort_capture", int'(state_o), 0);

        // arm and trigger edge in the same cycle: arm only
        tick();
        cmd_valid = 1'b1; cmd_data = ARM; trig = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("arm_trig_same", int'(state_o), 1);
        repeat (2) tick();
        chk("arm_trig_no_cap", int'(state_o), 1);
        trig = 1'b0;
        send_cmd(ABT);
        chk("abort_armed", int'(state_o), 0);

        // abort after 3 samples, coincident with a strobe: abort wins
        clear_mon();
        arm_and_trig();
        feed(3, 2, 1'b0);
        cmd_valid = 1'b1; cmd_data = ABT; smp_stb = 1'b1;
        tick();
        cmd_valid = 1'b0; smp_stb = 1'b0;
        chk("abort_idle", int'(state_o), 0);
        chk("abort_wren", int'(ram_wren), 0);
        chk("abort_addr", int'(ram_addr), 0);
        repeat (3) tick();
        chk("abort_wr_count", wa_q.size(), 3);

        // restart after abort begins again at address 0
        clear_mon();
        busy_len = $urandom_range(6, 1);
        arm_and_trig();
        feed(DEPTH, 2, 1'b0);
        wait_done(1'b0);
        check_capture();

        // abort in the middle of the dump: no done pulse
        clear_mon();
        busy_len = 4;
        arm_and_trig();
        feed(DEPTH, 1, 1'b0);
        for (int i = 0; i < 500 && state_o != 3'd6; i++) tick();
        chk("reach_wait_tx", int'(state_o), 6);
        repeat (4) tick();
        send_cmd(ABT);
        chk("dump_abort_idle", int'(state_o), 0);
        chk("dump_abort_txs", int'(tx_start), 0);
        repeat (30) tick();
        chk("dump_abort_no_done", done_cnt, 0);
        chk("dump_abort_stays", int'(state_o), 0);
        chk("dump_abort_partial", int'(tb_q.size() < 2 * DEPTH), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
